// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   CMD_W        width of the command field
//   alu_cmd_e    operation codes (values 9..15 are illegal)
//   alu_state_e  control state of alu_seq (IDLE / BUSY)
package alu_pkg;

    localparam int CMD_W = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_ADD  = 4'd0,
        CMD_SUB  = 4'd1,
        CMD_XOR  = 4'd2,
        CMD_SLT  = 4'd3,
        CMD_AND  = 4'd4,
        CMD_NAND = 4'd5,
        CMD_NOR  = 4'd6,
        CMD_OR   = 4'd7,
        CMD_MUL  = 4'd8
    } alu_cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier, one multiplier bit
// per clock.
//   clk, reset_n   clock, asynchronous active-low reset
//   start          load operands and begin WIDTH iterations
//   multiplicand   operand captured on start
//   multiplier     operand captured on start
//   lo, hi         low / high product halves, valid while done is high
//   done           high during the cycle whose rising edge performs the
//                  final iteration
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mplr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplr_next;

    // {acc, mplr} is one 2*WIDTH product register: each step adds the
    // multiplicand into the upper half when the current multiplier LSB is
    // set, then shifts the whole register right by one.
    always_comb begin
        addend    = mplr_q[0] ? {1'b0, mcand_q} : '0;
        add_sum   = {1'b0, acc_q} + addend;
        acc_next  = add_sum[WIDTH:1];
        mplr_next = {add_sum[0], mplr_q[WIDTH-1:1]};
    end

    // Exposing the post-iteration value lets the owner capture the product
    // on the same edge that performs the last step.
    assign done = (cnt_q == CNT_W'(1));
    assign lo   = mplr_next;
    assign hi   = acc_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            mcand_q <= multiplicand;
            acc_q   <= '0;
            mplr_q  <= multiplier;
            cnt_q   <= CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_q  <= acc_next;
            mplr_q <= mplr_next;
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and flags, plus an
// iterative multi-cycle MUL.
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake (a, b, command)
//   a, b                    two's-complement operands
//   command                 alu_cmd_e code; 9..15 raise err
//   out_valid / out_ready   result handshake
//   result                  registered result
//   carryout, overflow,
//   zero, err               registered flags
//   state                   current control state (debug observation)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high in IDLE when the output register is empty or
// being drained this cycle, so single-cycle ops stream at one per clock.
// The output register holds steady while out_valid && !out_ready.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CMD_W-1:0] command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             err,
    output alu_state_e       state
);

    alu_state_e       state_q, state_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             e_q, e_d;

    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] mul_hi;
    logic             mul_done;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_e;

    assign in_ready  = (state_q == IDLE) && (!ov_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (command == CMD_MUL);
    assign mul_start = accept && is_mul;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (mul_start),
        .multiplicand (a),
        .multiplier   (b),
        .lo           (mul_lo),
        .hi           (mul_hi),
        .done         (mul_done)
    );

    // Single-cycle datapath. SUB is a + ~b + 1 so its carry is the
    // unsigned "a >= b" indication; SLT reuses it with sign ^ overflow.
    always_comb begin
        add_sum = {1'b0, a} + {1'b0, b};
        sub_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);

        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_e   = 1'b0;
        case (command)
            CMD_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = add_ovf;
            end
            CMD_SUB: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_v   = sub_ovf;
            end
            CMD_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ sub_ovf};
            CMD_XOR:  alu_res = a ^ b;
            CMD_AND:  alu_res = a & b;
            CMD_NAND: alu_res = ~(a & b);
            CMD_NOR:  alu_res = ~(a | b);
            CMD_OR:   alu_res = a | b;
            CMD_MUL:  alu_res = '0;
            default:  alu_e   = 1'b1;
        endcase
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d = state_q;
        ov_d    = ov_q;
        res_d   = res_q;
        c_d     = c_q;
        v_d     = v_q;
        z_d     = z_q;
        e_d     = e_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        // Any drained result is gone; nothing new until the
                        // product is ready.
                        state_d = BUSY;
                        ov_d    = 1'b0;
                    end else begin
                        ov_d  = 1'b1;
                        res_d = alu_res;
                        c_d   = alu_c;
                        v_d   = alu_v;
                        z_d   = (alu_res == '0);
                        e_d   = alu_e;
                    end
                end else if (ov_q && out_ready) begin
                    ov_d = 1'b0;
                end
            end
            BUSY: begin
                if (mul_done) begin
                    state_d = IDLE;
                    ov_d    = 1'b1;
                    res_d   = mul_lo;
                    c_d     = (mul_hi != '0);
                    v_d     = 1'b0;
                    z_d     = (mul_lo == '0);
                    e_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ov_q    <= 1'b0;
            res_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ov_q    <= ov_d;
            res_q   <= res_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
            e_q     <= e_d;
        end
    end

    assign out_valid = ov_q;
    assign result    = res_q;
    assign carryout  = c_q;
    assign overflow  = v_q;
    assign zero      = z_q;
    assign err       = e_q;
    assign state     = state_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 32-bit combinational ALU. It registers every result together with its carry-out, overflow and zero flags, and adds an iterative multi-cycle multiply. Both input and output use valid/ready flow control, so the block can sit between the operand-fetch and writeback stages of a pipelined datapath. Single-cycle operations sustain one result per clock; MUL holds off new input until it completes.

## Interface
- WIDTH, 32: operand and result width; legal range 4..64.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/command presented.
- in_ready  out  1  block accepts the operation this cycle.
- a, b  in  WIDTH  operands, two's complement.
- command  in  4  operation code: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 MUL; 9..15 illegal.
- out_valid  out  1  result registers hold an undelivered result.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  registered result.
- carryout, overflow, zero, err  out  1 each  registered flags.

## Operation
- Transfer occurs when valid and ready are both high at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- ADD: result = a+b.
  - carryout = bit WIDTH of the unsigned sum.
  - overflow = operand signs equal and result sign differs.
- SUB: computed as a + ~b + 1.
  - carryout = 1 iff a >= b unsigned.
  - overflow = operand signs differ and result sign differs from a.
- SLT: signed compare via the SUB path.
  - result = {0…, sub_sign ^ sub_overflow}.
  - carryout = 0, overflow = 0.
- XOR, AND, NAND, NOR, OR: bitwise; carryout = 0, overflow = 0.
- MUL: unsigned shift-add, one multiplier bit per cycle.
  - result = low WIDTH bits of the product.
  - carryout = 1 iff the high WIDTH bits are nonzero; overflow = 0.
- Illegal command: result = 0, err = 1, other flags 0 except zero.
- zero = (result == 0) for every command, including illegal ones.
- err = 0 for all legal commands.
- State machine:
  - IDLE → BUSY on acceptance of MUL; the operands and a bit counter are loaded.
  - BUSY → IDLE after WIDTH iterations; the product is written to the output registers and out_valid is set on the same edge.
  - Non-MUL commands never leave IDLE.
- Output registers hold their value, unchanged, while out_valid && !out_ready.
- Simultaneous drain and accept: the new result overwrites and out_valid stays 1. If the accepted command is MUL, out_valid falls to 0 and the state goes to BUSY.
- in_valid, a, b and command are ignored while in_ready = 0.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, carryout 0, overflow 0, zero 0, err 0, counter 0. in_ready = 1 after reset.
- Single-cycle operations: accepted at edge N, out_valid = 1 after edge N. Throughput is 1 per cycle under continuous out_ready.
- MUL: accepted at edge N, out_valid = 1 after edge N+WIDTH. in_ready = 0 throughout BUSY.
- reset_n asserted mid-MUL or while holding a result: aborts immediately to the reset values; the partial product is discarded.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready only.

## Structure
- Shared package alu_pkg:
  - alu_cmd_e enum with the command codes above.
  - alu_state_e enum {IDLE, BUSY}.
  - Helper constant CMD_W = 4.
- Sub-module alu_mul_seq, owned by the top, implements the iterative multiplier:
  - Inputs: start, multiplicand, multiplier.
  - Outputs: WIDTH-bit low and high product halves, and a done pulse.
- The add/sub/SLT datapath and the flag logic stay in the top module.

## Test plan
- WIDTH=32, ADD 0x7fffffff + 0x00000001 → result 0x80000000, overflow 1, carryout 0, zero 0, one cycle after acceptance.
- SUB 0xffffffff − 0xffffffff → result 0, zero 1, carryout 1. SLT 0xf1011111 vs 0x10101100 → result 1. SLT 0x80000000 vs 0x7fffffff → result 1.
- MUL 0x00010000 × 0x00010000 → result 0, carryout 1, zero 1; out_valid exactly 32 cycles after acceptance; in_ready low during that time.
- Back-to-back XOR, AND, OR with out_ready held low after the first: the first result is held stable and in_ready = 0. Releasing out_ready delivers all three results in order, one per cycle.
- reset_n pulsed low 10 cycles into a MUL → out_valid 0, state IDLE, in_ready 1. A following ADD 2+3 → result 5.
- WIDTH=8, command 12 → result 0, err 1, zero 1. MUL 0x0f × 0x11 → result 0xff, carryout 0, valid after 8 cycles.
